// File: rtl/weighted_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared arbiter types and index helpers.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weighted_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : weighted_rr_arbiter_if
// Brief    : Request/weight/ack and grant bundle between requesters and arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface weighted_rr_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = idx_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic                        grant_ack;
  logic                        grant_valid;
  logic [IDX_W-1:0]            grant_idx;
  logic [NUM_REQ-1:0]          grant_onehot;
  logic                        grant_last;

  modport master (
    output req, weight, grant_ack,
    input  grant_valid, grant_idx, grant_onehot, grant_last
  );

  modport slave (
    input  req, weight, grant_ack,
    output grant_valid, grant_idx, grant_onehot, grant_last
  );
endinterface
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational circular first-set search of req starting at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [IDX_W-1:0]   ptr,
  output logic                    found,
  output logic [IDX_W-1:0]        idx
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   first;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum;

  // Rotate so ptr lands at bit 0, isolate lowest set bit, then undo rotation.
  assign dbl   = {req, req} >> ptr;
  assign rot   = dbl[NUM_REQ-1:0];
  assign first = rot & (~rot + NUM_REQ'(1));

  for (genvar b = 0; b < IDX_W; b++) begin : g_bit
    logic [NUM_REQ-1:0] col;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_row
      assign col[g] = 1'((g >> b) & 1);
    end
    assign off[b] = |(first & col);
  end

  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                              : sum[IDX_W-1:0];
  assign found = |req;
endmodule
`default_nettype wire

// File: rtl/weighted_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : weighted_rr_arbiter
// Brief    : Weighted round-robin arbiter holding each grant for up to weight+1 acks.
// Revision : 1.0 - initial release
// ============================================================================
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  weighted_rr_arbiter_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t          state, state_nx;
  logic [IDX_W-1:0]    ptr, ptr_nx;
  logic [IDX_W-1:0]    idx_r, idx_nx;
  logic [WEIGHT_W-1:0] credit, credit_nx;
  logic [IDX_W-1:0]    pick_ptr, pick_idx;
  logic                pick_found;
  logic                release_grant;
  logic [WEIGHT_W-1:0] w_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_w
    assign w_arr[g] = bus.weight[g*WEIGHT_W +: WEIGHT_W];
  end

  assign release_grant = (state == GRANT) &&
                         (!bus.req[idx_r] || (bus.grant_ack && credit == '0));

  // On release the search starts just past the holder so it ranks last.
  assign pick_ptr = release_grant ? IDX_W'(next_idx(int'(idx_r), NUM_REQ)) : ptr;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    idx_nx    = idx_r;
    credit_nx = credit;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx  = GRANT;
          idx_nx    = pick_idx;
          credit_nx = w_arr[pick_idx];
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_nx = pick_ptr;
          if (pick_found) begin
            idx_nx    = pick_idx;
            credit_nx = w_arr[pick_idx];
          end else begin
            state_nx = IDLE;
          end
        end else if (bus.grant_ack) begin
          credit_nx = credit - WEIGHT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx_r  <= '0;
      credit <= '0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      idx_r  <= idx_nx;
      credit <= credit_nx;
    end
  end

  assign bus.grant_valid = (state == GRANT);
  assign bus.grant_idx   = idx_r;
  assign bus.grant_last  = (state == GRANT) && (credit == '0);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_oh
    assign bus.grant_onehot[g] = (state == GRANT) && (idx_r == IDX_W'(g));
  end
endmodule
`default_nettype wire

// File: tb/tb_weighted_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_weighted_rr_arbiter
// Brief    : Scoreboard bench for 4- and 3-requester arbiters against a turn-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weighted_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weighted_rr_arbiter_if #(.NUM_REQ(4), .WEIGHT_W(4), .IDX_W(2)) bus4 ();
  weighted_rr_arbiter_if #(.NUM_REQ(3), .WEIGHT_W(4), .IDX_W(2)) bus3 ();

  weighted_rr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  weighted_rr_arbiter #(.NUM_REQ(3), .WEIGHT_W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic valid;
    int   idx;
    logic last;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;

  // Model: a turn is the holder plus acks served so far out of weight+1.
  int m_valid[2], m_idx[2], m_ptr[2], m_turns[2], m_done[2];

  function automatic int pick(input int n, input int start, input logic [3:0] rq);
    for (int k = 0; k < n; k++) begin
      if (rq[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_turns[d] = 0; m_done[d] = 0;
    end
  endtask

  task automatic start_turn(input int d, input int n, input logic [3:0] rq, input logic [15:0] wt);
    int w;
    w = pick(n, m_ptr[d], rq);
    if (w < 0) begin
      m_valid[d] = 0;
    end else begin
      m_valid[d] = 1; m_idx[d] = w; m_done[d] = 0;
      m_turns[d] = int'(wt[4*w +: 4]) + 1;
    end
  endtask

  task automatic model_step(input int d, input int n, input logic [3:0] rq,
                            input logic [15:0] wt, input logic ack, output exp_t e);
    bit rel;
    if (m_valid[d] == 0) begin
      start_turn(d, n, rq, wt);
    end else begin
      rel = 0;
      if (!rq[m_idx[d]]) rel = 1;
      else if (ack) begin
        m_done[d]++;
        if (m_done[d] == m_turns[d]) rel = 1;
      end
      if (rel) begin
        m_ptr[d] = (m_idx[d] + 1) % n;
        start_turn(d, n, rq, wt);
      end
    end
    e.valid = (m_valid[d] != 0);
    e.idx   = m_idx[d];
    e.last  = (m_valid[d] != 0) && (m_done[d] == m_turns[d] - 1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] rq, input logic [15:0] wt, input logic ack);
    exp_t e;
    @(negedge clk);
    bus4.req = rq;        bus4.weight = wt;        bus4.grant_ack = ack;
    bus3.req = rq[2:0];   bus3.weight = wt[11:0];  bus3.grant_ack = ack;
    model_step(0, 4, rq, wt, ack, e);
    q4.push_back(e);
    model_step(1, 3, {1'b0, rq[2:0]}, {4'h0, wt[11:0]}, ack, e);
    q3.push_back(e);
  endtask

  // Monitor: compares each registered output set against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("dut4 valid", int'(bus4.grant_valid), int'(e.valid));
      chk("dut4 onehot", int'(bus4.grant_onehot), e.valid ? (1 << e.idx) : 0);
      chk("dut4 last", int'(bus4.grant_last), int'(e.last));
      if (e.valid) chk("dut4 idx", int'(bus4.grant_idx), e.idx);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("dut3 valid", int'(bus3.grant_valid), int'(e.valid));
      chk("dut3 onehot", int'(bus3.grant_onehot), e.valid ? (1 << e.idx) : 0);
      chk("dut3 last", int'(bus3.grant_last), int'(e.last));
      if (e.valid) chk("dut3 idx", int'(bus3.grant_idx), e.idx);
    end
  end

  initial begin
    logic [15:0] wt;
    logic [3:0]  rq;
    rst = 1'b0;
    bus4.req = '0; bus4.weight = '0; bus4.grant_ack = 1'b0;
    bus3.req = '0; bus3.weight = '0; bus3.grant_ack = 1'b0;
    model_reset();
    #12;
    chk("reset valid", int'(bus4.grant_valid), 0);
    chk("reset idx", int'(bus4.grant_idx), 0);
    chk("reset onehot", int'(bus4.grant_onehot), 0);
    chk("reset last", int'(bus4.grant_last), 0);
    chk("reset dut3 valid", int'(bus3.grant_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // Sole requester with weight 2: three acks per turn, then re-granted.
    for (int i = 0; i < 9; i++) cycle(4'b0001, 16'h0002, 1'b1);
    // All requesters, weight 0: one transfer each, continuous rotation.
    for (int i = 0; i < 10; i++) cycle(4'b1111, 16'h0000, 1'b1);
    // Weights 3 and 1 on requesters 0 and 2.
    for (int i = 0; i < 14; i++) cycle(4'b0101, 16'h0103, 1'b1);
    cycle(4'b0000, 16'h0000, 1'b0);
    cycle(4'b0000, 16'h0000, 1'b0);
    // Holder 1 drops mid-grant without ack; requester 3 takes over with its weight.
    cycle(4'b0010, 16'h2050, 1'b0);
    cycle(4'b0010, 16'h2050, 1'b1);
    cycle(4'b1000, 16'h2050, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b1000, 16'h2050, 1'b1);
    // Ack while idle must be ignored.
    for (int i = 0; i < 3; i++) cycle(4'b0000, 16'h0000, 1'b1);

    wt = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      if (i % 32 == 0) wt = 16'($urandom) & 16'h3333;
      rq = 4'($urandom);
      cycle(rq, wt, ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset mid-grant.
    for (int i = 0; i < 3; i++) cycle(4'b1111, 16'h3333, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst valid", int'(bus4.grant_valid), 0);
    chk("async rst onehot", int'(bus4.grant_onehot), 0);
    chk("async rst last", int'(bus4.grant_last), 0);
    chk("async rst dut3 valid", int'(bus3.grant_valid), 0);
    q4.delete();
    q3.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) cycle(4'b1010, 16'h0101, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
